// File: rtl/cic_pkg.sv
// Shared types and helpers for the PDM->PCM CIC decimator.
package cic_pkg;

    localparam int CIC_MAX_CH = 4;

    typedef logic [1:0] cic_ch_t;

    // PDM bit to a two-bit signed sample: 1 -> +1, 0 -> -1.
    function automatic logic signed [1:0] pdm_to_signed(input logic pdm);
        return pdm ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage with a separate accumulator for each time-multiplexed channel.
module cic_integrator
    import cic_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  cic_ch_t          sel_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] bank [CIC_MAX_CH];

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            for (int i = 0; i < CIC_MAX_CH; i++) begin
                bank[i] <= '0;
            end
        end else if (en_i) begin
            bank[sel_i] <= bank[sel_i] + data_i;
        end
    end

    // Pre-update value, so the next stage in the chain integrates the old sum.
    assign data_o = bank[sel_i];

endmodule

// File: rtl/cic_integrator_decim.sv
// CIC integrator cascade with channel sequencing and frame-based decimation; feeds the comb chain.
module cic_integrator_decim
    import cic_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int STAGES  = 5,
    parameter int DECIM_W = 10
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [1:0]         ch_mode_i,
    input  logic [DECIM_W-1:0] decim_i,
    input  logic               pdm_i,
    input  logic               pdm_valid_i,
    output logic [WIDTH-1:0]   data_o,
    output logic [1:0]         sel_o,
    output logic               valid_o
);

    logic                 accept;
    logic signed [1:0]    pdm_s;
    logic [WIDTH-1:0]     x;
    cic_ch_t              r_ch;
    cic_ch_t              ch;
    logic [DECIM_W-1:0]   r_dec;
    logic                 frame_end;
    logic                 decimating;
    logic [WIDTH-1:0]     stage_in  [STAGES];
    logic [WIDTH-1:0]     stage_out [STAGES];
    logic [WIDTH-1:0]     last_next;

    assign accept     = en_i & pdm_valid_i & ~clr_i;
    assign pdm_s      = pdm_to_signed(pdm_i);
    assign x          = {{(WIDTH-2){pdm_s[1]}}, pdm_s};
    // An out-of-range pointer (ch_mode lowered without a clear) restarts at channel 0.
    assign ch         = (r_ch > ch_mode_i) ? cic_ch_t'(0) : r_ch;
    assign frame_end  = (ch == ch_mode_i);
    assign decimating = (r_dec >= decim_i);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_in[k] = x;
        end else begin : g_chain
            assign stage_in[k] = stage_out[k-1];
        end

        cic_integrator #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .en_i   (accept),
            .clr_i  (clr_i),
            .sel_i  (ch),
            .data_i (stage_in[k]),
            .data_o (stage_out[k])
        );
    end

    assign last_next = stage_out[STAGES-1] + stage_in[STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            r_ch    <= '0;
            r_dec   <= '0;
            data_o  <= '0;
            sel_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (accept) begin
                r_ch <= frame_end ? cic_ch_t'(0) : ch + cic_ch_t'(1);
                if (frame_end) begin
                    r_dec <= decimating ? '0 : r_dec + DECIM_W'(1);
                end
                if (decimating) begin
                    valid_o <= 1'b1;
                    sel_o   <= ch;
                    data_o  <= last_next;
                end
            end
        end
    end

endmodule
